// File: rtl/bpu_pkg.sv
// +---------------------------------------------------------------------------+
// | bpu_pkg: shared encodings and constants for the branch predictor          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam int          IDX_W_DEF = 4;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

`default_nettype wire

// File: rtl/bpu_sat_ctr.sv
// +---------------------------------------------------------------------------+
// | bpu_sat_ctr: 2-bit saturating counter next-state                          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module bpu_sat_ctr
  import bpu_pkg::*;
(
  input  ctr_t cur,
  input  logic taken,
  input  logic force_st,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    if (force_st) begin
      nxt = ST;
    end else if (taken) begin
      if (cur != ST) nxt = ctr_t'(cur + 2'd1);
    end else begin
      if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// +---------------------------------------------------------------------------+
// | branch_predictor: direct-mapped BHT + BTB with registered redirect.       |
// | Optional BPU_STATS_EN builds resolved-branch / mispredict counters.       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module branch_predictor
  import bpu_pkg::*;
#(
  parameter int         IDX_W    = IDX_W_DEF,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_tgt,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_cond,
  input  logic        ex_is_jump,
  input  logic        ex_taken,
  input  logic [31:0] ex_tgt,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_tgt,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_br,
  output logic [31:0] stat_miss
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  ctr_t             ctr       [ENTRIES];
  logic             btb_valid [ENTRIES];
  logic [TAG_W-1:0] btb_tag   [ENTRIES];
  logic [31:0]      btb_tgt   [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             hit;
  logic             resolve;
  logic             mispredict;
  logic [31:0]      correct_pc;
  ctr_t             ctr_nxt;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Reads see pre-edge table state, so a same-index update is not bypassed.
  assign hit        = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign pred_taken = hit && ctr[if_idx][1];
  assign pred_tgt   = pred_taken ? btb_tgt[if_idx] : (if_pc + PC_INC);

  assign resolve    = ex_valid && (ex_is_cond || ex_is_jump);
  assign correct_pc = ex_taken ? ex_tgt : (ex_pc + PC_INC);
  assign mispredict = resolve &&
                      ((ex_pred_taken != ex_taken) || (ex_pred_tgt != correct_pc));

  bpu_sat_ctr u_sat_ctr (
    .cur      (ctr[ex_idx]),
    .taken    (ex_taken),
    .force_st (ex_is_jump),
    .nxt      (ctr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i]       <= ctr_t'(CTR_INIT);
        btb_valid[i] <= 1'b0;
        btb_tag[i]   <= '0;
        btb_tgt[i]   <= '0;
      end
    end else if (resolve) begin
      ctr[ex_idx] <= ctr_nxt;
      if (ex_taken) begin
        btb_valid[ex_idx] <= 1'b1;
        btb_tag[ex_idx]   <= ex_tag;
        btb_tgt[ex_idx]   <= ex_tgt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      redirect <= mispredict;
      if (mispredict) redirect_pc <= correct_pc;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (resolve)    br_cnt   <= br_cnt + 32'd1;
      if (mispredict) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign stat_br   = br_cnt;
  assign stat_miss = miss_cnt;
`else
  assign stat_br   = 32'd0;
  assign stat_miss = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// +---------------------------------------------------------------------------+
// | tb_branch_predictor: directed scoreboard bench for branch_predictor       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_tgt;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_cond;
  logic        ex_is_jump;
  logic        ex_taken;
  logic [31:0] ex_tgt;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_tgt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] stat_br;
  logic [31:0] stat_miss;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   exp_br = 0;
  int   exp_ms = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .pred_tgt      (pred_tgt),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_is_cond    (ex_is_cond),
    .ex_is_jump    (ex_is_jump),
    .ex_taken      (ex_taken),
    .ex_tgt        (ex_tgt),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_tgt   (ex_pred_tgt),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .stat_br       (stat_br),
    .stat_miss     (stat_miss)
  );

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      assert (obs === e.val)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic predict(input string tag, input logic [31:0] pc,
                         input logic exp_tk, input logic [31:0] exp_tgt);
    if_pc = pc;
    push({tag, "_taken"}, {31'd0, exp_tk});
    push({tag, "_tgt"}, exp_tgt);
    #1;
    compare({31'd0, pred_taken});
    compare(pred_tgt);
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic cond, input logic jump,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    ex_valid      = 1'b1;
    ex_pc         = pc;
    ex_is_cond    = cond;
    ex_is_jump    = jump;
    ex_taken      = tk;
    ex_tgt        = tgt;
    ex_pred_taken = ptk;
    ex_pred_tgt   = ptgt;
  endtask

  task automatic finish_ex(input string tag, input logic exp_redir,
                           input logic [31:0] exp_rpc);
    if (ex_is_cond || ex_is_jump) exp_br++;
    if (exp_redir) exp_ms++;
    push({tag, "_redirect"}, {31'd0, exp_redir});
    push({tag, "_redirect_pc"}, exp_rpc);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    compare({31'd0, redirect});
    compare(redirect_pc);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input logic cond,
                         input logic jump, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic exp_redir, input logic [31:0] exp_rpc);
    drive_ex(pc, cond, jump, tk, tgt, ptk, ptgt);
    finish_ex(tag, exp_redir, exp_rpc);
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 32'h0; ex_valid = 1'b0; ex_pc = 32'h0;
    ex_is_cond = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0; ex_tgt = 32'h0;
    ex_pred_taken = 1'b0; ex_pred_tgt = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset state
    push("rst_redirect", 32'd0);    compare({31'd0, redirect});
    push("rst_redirect_pc", 32'd0); compare(redirect_pc);
    push("rst_stat_br", 32'd0);     compare(stat_br);
    push("rst_stat_miss", 32'd0);   compare(stat_miss);
    predict("rst_pred", 32'h100, 1'b0, 32'h104);
    predict("wrap_pred", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // 2: first taken resolution mispredicts, then hits
    resolve("t2", 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 1'b1, 32'h80);
    @(posedge clk); #1;
    push("t2_one_cycle", 32'd0); compare({31'd0, redirect});
    predict("t2_pred", 32'h100, 1'b1, 32'h80);

    // 3: saturate, then two not-taken resolutions
    for (int i = 0; i < 3; i++)
      resolve("t3_tk", 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 1'b0, 32'h80);
    predict("t3_sat", 32'h100, 1'b1, 32'h80);
    resolve("t3_nt1", 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 1'b1, 32'h104);
    predict("t3_ctr10", 32'h100, 1'b1, 32'h80);
    resolve("t3_nt2", 32'h100, 1, 0, 0, 32'h80, 1, 32'h80, 1'b1, 32'h104);
    predict("t3_ctr01", 32'h100, 1'b0, 32'h104);
    @(posedge clk); #1;
    push("t3_hold_pc", 32'h104); compare(redirect_pc);

    // 4: jalr target change; same-index read during write sees the old entry
    resolve("t4a", 32'h200, 0, 1, 1, 32'h300, 0, 32'h204, 1'b1, 32'h300);
    predict("t4a_pred", 32'h200, 1'b1, 32'h300);
    drive_ex(32'h200, 0, 1, 1, 32'h340, 1, 32'h300);
    if_pc = 32'h200;
    push("t4_nobypass", 32'h300);
    #1 compare(pred_tgt);
    finish_ex("t4b", 1'b1, 32'h340);
    predict("t4b_pred", 32'h200, 1'b1, 32'h340);

    // neither cond nor jump: ignored
    resolve("t4_none", 32'h200, 0, 0, 1, 32'h500, 0, 32'h204, 1'b0, 32'h340);
    predict("t4_none_pred", 32'h200, 1'b1, 32'h340);

    // 5: aliasing at index 0
    resolve("t5a", 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 1'b1, 32'h80);
    predict("t5a_pred", 32'h100, 1'b1, 32'h80);
    resolve("t5b", 32'h140, 1, 0, 1, 32'h10, 0, 32'h144, 1'b1, 32'h10);
    predict("t5_alias_miss", 32'h100, 1'b0, 32'h104);
    predict("t5_alias_hit", 32'h140, 1'b1, 32'h10);

    // stats (before reset clears them)
    push("stat_br", `ifdef BPU_STATS_EN exp_br `else 32'd0 `endif);
    compare(stat_br);
    push("stat_miss", `ifdef BPU_STATS_EN exp_ms `else 32'd0 `endif);
    compare(stat_miss);

    // 6: reset right after a mispredict
    resolve("t6", 32'h140, 1, 0, 0, 32'h10, 1, 32'h10, 1'b1, 32'h144);
    rst_n = 1'b0;
    #1;
    push("t6_rst_redirect", 32'd0);    compare({31'd0, redirect});
    push("t6_rst_redirect_pc", 32'd0); compare(redirect_pc);
    @(posedge clk); #1 rst_n = 1'b1;
    predict("t6_p140", 32'h140, 1'b0, 32'h144);
    predict("t6_p200", 32'h200, 1'b0, 32'h204);
    predict("t6_p100", 32'h100, 1'b0, 32'h104);
    push("t6_stat_br", 32'd0); compare(stat_br);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
